// File: rtl/cpu_bus_timer.sv
// cpu_bus_timer: memory-mapped 16-bit interval timer on an 8-bit CPU bus.
//
// The CPU sees six byte registers at BASE_ADDR..BASE_ADDR+5:
//   0 RELOAD_LO (RW), 1 RELOAD_HI (RW), 2 CTRL (RW: [0]EN [1]IRQ_EN [2]ONESHOT),
//   3 STATUS (RO: [0]EXPIRED [7]running; a read clears EXPIRED),
//   4 COUNT_LO (RO), 5 COUNT_HI (RO).
// The prescaler divides clk_ph1 by PRESCALE to form timer ticks. COUNT
// decrements once per tick. A tick that finds COUNT==0 sets EXPIRED, then
// either reloads COUNT (periodic mode) or stops the timer (one-shot mode).
//
// Optional feature, macro CPU_TIMER_LATCH_EN: a COUNT_LO read captures
// COUNT[15:8] into a latch. COUNT_HI then returns that latch, so a LO-then-HI
// read is tear-free. Without the macro, COUNT_HI returns the live COUNT[15:8].
//
// Ports:
//   clk_ph1      in   1   sole clock, rising edge
//   rst          in   1   asynchronous active-low reset
//   Addr_bus     in  16   CPU address
//   R_nW         in   1   1 = read, 0 = write
//   Data_bus_out in   8   CPU write data
//   Data_bus_in  out  8   read data (combinational)
//   sel          out  1   address hit (combinational)
//   irq          out  1   active-low interrupt request (registered)
module cpu_bus_timer #(
    parameter logic [15:0] BASE_ADDR = 16'h4020,
    parameter int unsigned PRESCALE  = 8
) (
    input  logic        clk_ph1,
    input  logic        rst,
    input  logic [15:0] Addr_bus,
    input  logic        R_nW,
    input  logic [7:0]  Data_bus_out,
    output logic [7:0]  Data_bus_in,
    output logic        sel,
    output logic        irq
);

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned PRE_W   = 8;
    localparam int unsigned OFF_W   = 3;
    localparam int unsigned NUM_REG = 6;

    localparam logic [OFF_W-1:0] OFF_RELOAD_LO = 3'd0;
    localparam logic [OFF_W-1:0] OFF_RELOAD_HI = 3'd1;
    localparam logic [OFF_W-1:0] OFF_CTRL      = 3'd2;
    localparam logic [OFF_W-1:0] OFF_STATUS    = 3'd3;
    localparam logic [OFF_W-1:0] OFF_COUNT_LO  = 3'd4;
    localparam logic [OFF_W-1:0] OFF_COUNT_HI  = 3'd5;

    localparam logic [PRE_W-1:0] PRESC_LAST = PRE_W'(PRESCALE - 1);

    // Register state
    logic [CNT_W-1:0] reload;
    logic [CNT_W-1:0] count;
    logic [PRE_W-1:0] presc;
    logic             en;
    logic             irq_en;
    logic             oneshot;
    logic             expired;

    // Next-state values
    logic [CNT_W-1:0] reload_n;
    logic [CNT_W-1:0] count_n;
    logic [PRE_W-1:0] presc_n;
    logic             en_n;
    logic             irq_en_n;
    logic             oneshot_n;
    logic             expired_n;
    logic             irq_n;

`ifdef CPU_TIMER_LATCH_EN
    logic [DATA_W-1:0] hi_latch;
    logic [DATA_W-1:0] hi_latch_n;
`endif

    // Address decode
    logic [ADDR_W-1:0] offset;
    logic [OFF_W-1:0]  off;
    logic              wr;
    logic              rd;
    logic              tick;
    logic              start;

    assign offset = Addr_bus - BASE_ADDR;
    assign off    = offset[OFF_W-1:0];
    assign sel    = (Addr_bus >= BASE_ADDR) && (offset < ADDR_W'(NUM_REG));
    assign wr     = sel && !R_nW;
    assign rd     = sel && R_nW;

    // A tick happens on the edge where the prescaler wraps back to zero
    assign tick  = en && (presc == PRESC_LAST);
    // Only an EN 0->1 transition reloads; rewriting CTRL while running does not
    assign start = wr && (off == OFF_CTRL) && Data_bus_out[0] && !en;

    // Read data mux
    always_comb begin
        Data_bus_in = '0;
        if (sel) begin
            case (off)
                OFF_RELOAD_LO: Data_bus_in = reload[7:0];
                OFF_RELOAD_HI: Data_bus_in = reload[15:8];
                OFF_CTRL:      Data_bus_in = {5'b0, oneshot, irq_en, en};
                OFF_STATUS:    Data_bus_in = {en, 6'b0, expired};
                OFF_COUNT_LO:  Data_bus_in = count[7:0];
`ifdef CPU_TIMER_LATCH_EN
                OFF_COUNT_HI:  Data_bus_in = hi_latch;
`else
                OFF_COUNT_HI:  Data_bus_in = count[15:8];
`endif
                default:       Data_bus_in = '0;
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        reload_n  = reload;
        count_n   = count;
        presc_n   = presc;
        en_n      = en;
        irq_en_n  = irq_en;
        oneshot_n = oneshot;
        expired_n = expired;
`ifdef CPU_TIMER_LATCH_EN
        hi_latch_n = hi_latch;
`endif

        // Prescaler runs only while enabled
        if (en) begin
            presc_n = tick ? '0 : presc + PRE_W'(1);
        end

        // Tick handling
        if (tick) begin
            if (count != '0) begin
                count_n = count - CNT_W'(1);
            end else begin
                expired_n = 1'b1;
                if (oneshot) begin
                    en_n = 1'b0;
                end else begin
                    count_n = reload;
                end
            end
        end

        // Read side effects; a same-edge expiry overrides the clear
        if (rd && (off == OFF_STATUS) && !(tick && (count == '0))) begin
            expired_n = 1'b0;
        end
`ifdef CPU_TIMER_LATCH_EN
        if (rd && (off == OFF_COUNT_LO)) begin
            hi_latch_n = count[15:8];
        end
`endif

        // CPU writes; the start load takes priority over any tick
        if (wr) begin
            case (off)
                OFF_RELOAD_LO: reload_n[7:0]  = Data_bus_out;
                OFF_RELOAD_HI: reload_n[15:8] = Data_bus_out;
                OFF_CTRL: begin
                    en_n      = Data_bus_out[0];
                    irq_en_n  = Data_bus_out[1];
                    oneshot_n = Data_bus_out[2];
                end
                default: ;
            endcase
        end
        if (start) begin
            count_n = reload;
            presc_n = '0;
        end

        irq_n = !(expired_n && irq_en_n);
    end

    // State registers
    always_ff @(posedge clk_ph1 or negedge rst) begin
        if (!rst) begin
            reload  <= '0;
            count   <= '0;
            presc   <= '0;
            en      <= 1'b0;
            irq_en  <= 1'b0;
            oneshot <= 1'b0;
            expired <= 1'b0;
            irq     <= 1'b1;
`ifdef CPU_TIMER_LATCH_EN
            hi_latch <= '0;
`endif
        end else begin
            reload  <= reload_n;
            count   <= count_n;
            presc   <= presc_n;
            en      <= en_n;
            irq_en  <= irq_en_n;
            oneshot <= oneshot_n;
            expired <= expired_n;
            irq     <= irq_n;
`ifdef CPU_TIMER_LATCH_EN
            hi_latch <= hi_latch_n;
`endif
        end
    end

endmodule

// File: tb/tb_cpu_bus_timer.sv
// Testbench for cpu_bus_timer: directed bus cycles with a scoreboard queue.
// Stimulus pushes expected values; a negedge monitor pops and compares.
module tb_cpu_bus_timer;

    localparam logic [15:0] BASE = 16'h4020;

`ifdef CPU_TIMER_LATCH_EN
    localparam logic [7:0] LATCH_HI_EXP = 8'h01;
`else
    localparam logic [7:0] LATCH_HI_EXP = 8'h00;
`endif

    localparam int KIND_DATA = 0;
    localparam int KIND_IRQ  = 1;
    localparam int KIND_SEL  = 2;

    logic        clk_ph1;
    logic        rst;
    logic [15:0] Addr_bus;
    logic        R_nW;
    logic [7:0]  Data_bus_out;
    logic [7:0]  Data_bus_in;
    logic        sel;
    logic        irq;

    typedef struct {
        int         kind;
        logic [7:0] value;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic done   = 1'b0;

    cpu_bus_timer #(
        .BASE_ADDR(BASE),
        .PRESCALE (8)
    ) dut (
        .clk_ph1     (clk_ph1),
        .rst         (rst),
        .Addr_bus    (Addr_bus),
        .R_nW        (R_nW),
        .Data_bus_out(Data_bus_out),
        .Data_bus_in (Data_bus_in),
        .sel         (sel),
        .irq         (irq)
    );

    initial begin
        clk_ph1 = 1'b0;
        forever #5 clk_ph1 = ~clk_ph1;
    end

    // Monitor: compares every pending expectation at the falling edge
    always @(negedge clk_ph1) begin
        exp_t       e;
        logic [7:0] act;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.kind)
                KIND_IRQ: act = {7'b0, irq};
                KIND_SEL: act = {7'b0, sel};
                default:  act = Data_bus_in;
            endcase
            checks++;
            if (act !== e.value) begin
                errors++;
                $display("FAIL %s: got %02h expected %02h at %0t", e.name, act, e.value, $time);
            end
        end
        if (done) begin
            if (checks < 12) begin
                errors++;
                $display("FAIL too few checks: %0d", checks);
            end
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic push(input int kind, input logic [7:0] v, input string nm);
        exp_t e;
        e.kind  = kind;
        e.value = v;
        e.name  = nm;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        Addr_bus     = 16'h0000;
        R_nW         = 1'b1;
        Data_bus_out = 8'h00;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_ph1);
        #1;
    endtask

    task automatic wr(input logic [2:0] off, input logic [7:0] d);
        Addr_bus     = BASE + 16'(off);
        R_nW         = 1'b0;
        Data_bus_out = d;
        cycles(1);
        idle();
    endtask

    task automatic rd(input logic [2:0] off, input logic [7:0] v, input string nm);
        Addr_bus = BASE + 16'(off);
        R_nW     = 1'b1;
        push(KIND_DATA, v, nm);
        cycles(1);
        idle();
    endtask

    task automatic probe(input logic [15:0] a, input logic s, input logic [7:0] v, input string nm);
        Addr_bus = a;
        R_nW     = 1'b1;
        push(KIND_SEL, {7'b0, s}, nm);
        push(KIND_DATA, v, nm);
        cycles(1);
        idle();
    endtask

    task automatic expect_irq(input logic v, input string nm);
        push(KIND_IRQ, {7'b0, v}, nm);
    endtask

    initial begin
        rst = 1'b0;
        idle();
        cycles(2);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL reset_irq_direct: got %b at %0t", irq, $time);
        end
        expect_irq(1'b1, "reset_irq");
        rd(3'd2, 8'h00, "reset_ctrl");
        rst = 1'b1;
        cycles(1);

        // Periodic, RELOAD=3: expiry 32 clocks after start, then every 32
        wr(3'd0, 8'h03);
        wr(3'd1, 8'h00);
        rd(3'd0, 8'h03, "reload_lo_rb");
        wr(3'd2, 8'h03);                      // E0
        cycles(31);
        expect_irq(1'b1, "per_before_exp");   // E31
        cycles(1);
        expect_irq(1'b0, "per_first_exp");    // E32
        rd(3'd3, 8'h81, "per_status");
        expect_irq(1'b1, "per_ack");          // E33
        rd(3'd4, 8'h03, "per_count_reloaded");
        cycles(29);
        expect_irq(1'b1, "per2_before");      // E63
        cycles(1);
        expect_irq(1'b0, "per2_exp");         // E64
        rd(3'd3, 8'h81, "per2_status");
        cycles(30);                           // E95
        rd(3'd3, 8'h80, "race_status");       // read commits on E96 expiry
        expect_irq(1'b0, "race_irq_low");
        rd(3'd3, 8'h81, "race_expired_kept");
        expect_irq(1'b1, "race_ack");

        // One-shot, RELOAD=1: single expiry after 2 ticks
        wr(3'd2, 8'h00);
        rd(3'd3, 8'h00, "stopped_status");
        wr(3'd0, 8'h01);
        wr(3'd1, 8'h00);
        wr(3'd2, 8'h07);                      // F0
        rd(3'd2, 8'h07, "os_ctrl_rb");
        cycles(14);
        expect_irq(1'b1, "os_before");        // F15
        cycles(1);
        expect_irq(1'b0, "os_exp");           // F16
        rd(3'd3, 8'h01, "os_status");
        expect_irq(1'b1, "os_ack");
        rd(3'd4, 8'h00, "os_count_lo");
        rd(3'd5, 8'h00, "os_count_hi");
        rd(3'd2, 8'h06, "os_ctrl_en_cleared");
        cycles(40);
        expect_irq(1'b1, "os_no_more_irq");
        rd(3'd3, 8'h00, "os_status_quiet");

        // Live reload: RELOAD 5 -> 9 mid-period
        wr(3'd0, 8'h05);
        wr(3'd1, 8'h00);
        wr(3'd2, 8'h03);                      // G0
        cycles(9);
        wr(3'd0, 8'h09);                      // G10
        cycles(37);
        expect_irq(1'b1, "live_before");      // G47
        cycles(1);
        expect_irq(1'b0, "live_exp1");        // G48
        rd(3'd3, 8'h81, "live_status1");
        cycles(78);
        expect_irq(1'b1, "live_before2");     // G127
        cycles(1);
        expect_irq(1'b0, "live_exp2");        // G128
        rd(3'd3, 8'h81, "live_status2");

        // Latch: COUNT=0100, read LO, tick to 00FF, read HI
        wr(3'd2, 8'h00);
        wr(3'd0, 8'h00);
        wr(3'd1, 8'h01);
        wr(3'd2, 8'h01);                      // H0
        rd(3'd4, 8'h00, "latch_lo");          // H1
        cycles(7);                            // H8 tick
        rd(3'd5, LATCH_HI_EXP, "latch_hi");
        rd(3'd4, 8'hFF, "latch_lo_after_tick");

        // RELOAD=0 periodic, then reset mid-run with irq low
        wr(3'd2, 8'h00);
        wr(3'd0, 8'h00);
        wr(3'd1, 8'h00);
        wr(3'd2, 8'h03);                      // K0
        cycles(8);
        expect_irq(1'b0, "r0_exp");           // K8
        @(negedge clk_ph1);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL rst_irq_immediate: got %b at %0t", irq, $time);
        end
        cycles(1);
        expect_irq(1'b1, "rst_irq");
        for (int i = 0; i < 6; i++) begin
            rd(3'(i), 8'h00, "rst_reg");
        end
        probe(16'h4026, 1'b0, 8'h00, "sel_above");
        probe(16'h401F, 1'b0, 8'h00, "sel_below");
        probe(16'h4025, 1'b1, 8'h00, "sel_top");
        rst = 1'b1;
        cycles(1);

        // Writes to read-only offsets are ignored
        wr(3'd4, 8'h55);
        wr(3'd3, 8'hFF);
        Addr_bus = BASE + 16'd3;
        R_nW     = 1'b1;
        #1;
        checks++;
        if (sel !== 1'b1) begin
            errors++;
            $display("FAIL sel_status_direct: got %b at %0t", sel, $time);
        end
        checks++;
        if (Data_bus_in !== 8'h00) begin
            errors++;
            $display("FAIL ro_status_direct: got %02h at %0t", Data_bus_in, $time);
        end
        idle();
        rd(3'd4, 8'h00, "ro_count_lo");
        rd(3'd3, 8'h00, "ro_status");
        expect_irq(1'b1, "final_irq");
        done = 1'b1;
    end

endmodule
